// File: rtl/ctrl_pkg.sv
// ============================================================================
//  Module      : ctrl_pkg
//  Description : Shared states, opcodes, IR field positions and strobe types
//                for the control sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T0   = 3'd1,
        ST_T1   = 3'd2,
        ST_T2   = 3'd3,
        ST_T3   = 3'd4,
        ST_T4   = 3'd5,
        ST_T5   = 3'd6,
        ST_HALT = 3'd7
    } state_t;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int RC_MSB  = 18;
    localparam int RC_LSB  = 15;

    localparam logic [4:0] OP_ADD    = 5'b00000;
    localparam logic [4:0] OP_SUB    = 5'b00001;
    localparam logic [4:0] OP_AND    = 5'b00010;
    localparam logic [4:0] OP_OR     = 5'b00011;
    localparam logic [4:0] OP_SHR    = 5'b00100;
    localparam logic [4:0] OP_SHL    = 5'b00101;
    localparam logic [4:0] OP_ROR    = 5'b00110;
    localparam logic [4:0] OP_ROL    = 5'b00111;
    localparam logic [4:0] OP_MUL    = 5'b01000;
    localparam logic [4:0] OP_DIV    = 5'b01001;
    localparam logic [4:0] OP_NEGATE = 5'b01010;
    localparam logic [4:0] OP_NOT    = 5'b01011;
    localparam logic [4:0] OP_IN     = 5'b10000;
    localparam logic [4:0] OP_OUT    = 5'b10001;
    localparam logic [4:0] OP_MFLO   = 5'b10010;
    localparam logic [4:0] OP_NOP    = 5'b11000;
    localparam logic [4:0] OP_HALT   = 5'b11011;

    typedef enum logic [3:0] {
        CLS_BINARY  = 4'd0,
        CLS_UNARY   = 4'd1,
        CLS_MULDIV  = 4'd2,
        CLS_IN      = 4'd3,
        CLS_OUT     = 4'd4,
        CLS_MFLO    = 4'd5,
        CLS_NOP     = 4'd6,
        CLS_HALT    = 4'd7,
        CLS_ILLEGAL = 4'd8
    } iclass_t;

    localparam int ALU_W      = 12;
    localparam int ALU_ADD    = 0;
    localparam int ALU_SUB    = 1;
    localparam int ALU_MUL    = 2;
    localparam int ALU_DIV    = 3;
    localparam int ALU_SHR    = 4;
    localparam int ALU_SHL    = 5;
    localparam int ALU_ROR    = 6;
    localparam int ALU_ROL    = 7;
    localparam int ALU_AND    = 8;
    localparam int ALU_OR     = 9;
    localparam int ALU_NEGATE = 10;
    localparam int ALU_NOT    = 11;

    typedef struct packed {
        logic pc_in;
        logic ir_in;
        logic ry_in;
        logic rz_in;
        logic mar_in;
        logic hilo_in;
        logic mdr_in;
        logic output_in;
        logic read;
        logic input_out;
        logic mdr_out;
        logic hilo_out;
        logic rz_out;
        logic pc_out;
        logic inc_pc;
        logic retire;
    } ctl_t;

    function automatic logic [ALU_W-1:0] alu_onehot(input int idx);
        return ALU_W'(1) << idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ctrl_decode.sv
// ============================================================================
//  Module      : ctrl_decode
//  Description : Combinational opcode -> instruction class and ALU one-hot.
//                MUL/DIV decode only when CTRL_MULDIV_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [4:0]       opcode,
    output iclass_t          iclass,
    output logic [ALU_W-1:0] alu_sel
);

    always_comb begin
        iclass  = CLS_ILLEGAL;
        alu_sel = '0;
        case (opcode)
            OP_ADD:    begin iclass = CLS_BINARY; alu_sel = alu_onehot(ALU_ADD);    end
            OP_SUB:    begin iclass = CLS_BINARY; alu_sel = alu_onehot(ALU_SUB);    end
            OP_AND:    begin iclass = CLS_BINARY; alu_sel = alu_onehot(ALU_AND);    end
            OP_OR:     begin iclass = CLS_BINARY; alu_sel = alu_onehot(ALU_OR);     end
            OP_SHR:    begin iclass = CLS_BINARY; alu_sel = alu_onehot(ALU_SHR);    end
            OP_SHL:    begin iclass = CLS_BINARY; alu_sel = alu_onehot(ALU_SHL);    end
            OP_ROR:    begin iclass = CLS_BINARY; alu_sel = alu_onehot(ALU_ROR);    end
            OP_ROL:    begin iclass = CLS_BINARY; alu_sel = alu_onehot(ALU_ROL);    end
`ifdef CTRL_MULDIV_EN
            OP_MUL:    begin iclass = CLS_MULDIV; alu_sel = alu_onehot(ALU_MUL);    end
            OP_DIV:    begin iclass = CLS_MULDIV; alu_sel = alu_onehot(ALU_DIV);    end
`endif
            OP_NEGATE: begin iclass = CLS_UNARY;  alu_sel = alu_onehot(ALU_NEGATE); end
            OP_NOT:    begin iclass = CLS_UNARY;  alu_sel = alu_onehot(ALU_NOT);    end
            OP_IN:     iclass = CLS_IN;
            OP_OUT:    iclass = CLS_OUT;
            OP_MFLO:   iclass = CLS_MFLO;
            OP_NOP:    iclass = CLS_NOP;
            OP_HALT:   iclass = CLS_HALT;
            default:   iclass = CLS_ILLEGAL;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/control_sequencer.sv
// ============================================================================
//  Module      : control_sequencer
//  Description : Moore control-step sequencer (fetch T0-T2, execute T3-T5).
//                Optional MUL/DIV support via CTRL_MULDIV_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int BITS      = 32,
    parameter int REGISTERS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 mem_ready,
    input  logic [BITS-1:0]      ir,
    output logic [REGISTERS-1:0] GPRin,
    output logic [REGISTERS-1:0] GPRout,
    output logic PCin, IRin, RYin, RZin, MARin, HILOin, MDRin, OUTPUTin, Read,
    output logic INPUTout, MDRout, HILOout, RZout, PCout, BAout,
    output logic ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT, IncPC,
    output logic busy,
    output logic halted,
    output logic illegal,
    output logic retire
);

    state_t               state_q, state_d;
    logic                 illegal_q, illegal_d;
    iclass_t              w_cls;
    logic [ALU_W-1:0]     w_alu_sel;
    logic [ALU_W-1:0]     w_alu;
    ctl_t                 w_ctl;
    logic [REGISTERS-1:0] w_gpr_in, w_gpr_out;
    logic [3:0]           w_ra, w_rb, w_rc;
    logic                 unused_ir;

    assign w_ra      = ir[RA_MSB:RA_LSB];
    assign w_rb      = ir[RB_MSB:RB_LSB];
    assign w_rc      = ir[RC_MSB:RC_LSB];
    assign unused_ir = ^ir[RC_LSB-1:0];

    function automatic logic [REGISTERS-1:0] reg_sel(input logic [3:0] idx);
        return {{(REGISTERS-1){1'b0}}, 1'b1} << idx;
    endfunction

    ctrl_decode u_decode (
        .opcode  (ir[OPC_MSB:OPC_LSB]),
        .iclass  (w_cls),
        .alu_sel (w_alu_sel)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        w_ctl     = '0;
        w_alu     = '0;
        w_gpr_in  = '0;
        w_gpr_out = '0;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_T0;
            ST_T0: begin
                w_ctl.pc_out = 1'b1;
                w_ctl.mar_in = 1'b1;
                w_ctl.inc_pc = 1'b1;
                w_ctl.rz_in  = 1'b1;
                state_d      = ST_T1;
            end
            ST_T1: begin
                w_ctl.rz_out = 1'b1;
                w_ctl.pc_in  = 1'b1;
                w_ctl.read   = 1'b1;
                w_ctl.mdr_in = 1'b1;
                if (mem_ready) state_d = ST_T2;
            end
            ST_T2: begin
                w_ctl.mdr_out = 1'b1;
                w_ctl.ir_in   = 1'b1;
                state_d       = ST_T3;
            end
            ST_T3: begin
                state_d = ST_T0;
                case (w_cls)
                    CLS_BINARY, CLS_MULDIV: begin
                        w_gpr_out    = reg_sel(w_rb);
                        w_ctl.ry_in  = 1'b1;
                        state_d      = ST_T4;
                    end
                    CLS_UNARY: state_d = ST_T4;
                    CLS_IN: begin
                        w_ctl.input_out = 1'b1;
                        w_gpr_in        = reg_sel(w_ra);
                        w_ctl.retire    = 1'b1;
                    end
                    CLS_OUT: begin
                        w_gpr_out       = reg_sel(w_ra);
                        w_ctl.output_in = 1'b1;
                        w_ctl.retire    = 1'b1;
                    end
                    CLS_MFLO: begin
                        w_ctl.hilo_out = 1'b1;
                        w_gpr_in       = reg_sel(w_ra);
                        w_ctl.retire   = 1'b1;
                    end
                    CLS_NOP:  w_ctl.retire = 1'b1;
                    CLS_HALT: state_d = ST_HALT;
                    default: begin
                        state_d   = ST_HALT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            ST_T4: begin
                // Unary ops take their single source from Rb in this step
                w_gpr_out   = reg_sel((w_cls == CLS_UNARY) ? w_rb : w_rc);
                w_alu       = w_alu_sel;
                w_ctl.rz_in = 1'b1;
                state_d     = ST_T5;
            end
            ST_T5: begin
                w_ctl.rz_out = 1'b1;
                w_ctl.retire = 1'b1;
                if (w_cls == CLS_MULDIV) w_ctl.hilo_in = 1'b1;
                else                     w_gpr_in      = reg_sel(w_ra);
                state_d = ST_T0;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
        // Strobes are suppressed for the whole reset cycle, not just after it
        if (reset) begin
            w_ctl     = '0;
            w_alu     = '0;
            w_gpr_in  = '0;
            w_gpr_out = '0;
        end
    end

    assign GPRin    = w_gpr_in;
    assign GPRout   = w_gpr_out;
    assign PCin     = w_ctl.pc_in;
    assign IRin     = w_ctl.ir_in;
    assign RYin     = w_ctl.ry_in;
    assign RZin     = w_ctl.rz_in;
    assign MARin    = w_ctl.mar_in;
    assign HILOin   = w_ctl.hilo_in;
    assign MDRin    = w_ctl.mdr_in;
    assign OUTPUTin = w_ctl.output_in;
    assign Read     = w_ctl.read;
    assign INPUTout = w_ctl.input_out;
    assign MDRout   = w_ctl.mdr_out;
    assign HILOout  = w_ctl.hilo_out;
    assign RZout    = w_ctl.rz_out;
    assign PCout    = w_ctl.pc_out;
    assign BAout    = 1'b0;
    assign IncPC    = w_ctl.inc_pc;
    assign retire   = w_ctl.retire;

    assign ADD    = w_alu[ALU_ADD];
    assign SUB    = w_alu[ALU_SUB];
    assign MUL    = w_alu[ALU_MUL];
    assign DIV    = w_alu[ALU_DIV];
    assign SHR    = w_alu[ALU_SHR];
    assign SHL    = w_alu[ALU_SHL];
    assign ROR    = w_alu[ALU_ROR];
    assign ROL    = w_alu[ALU_ROL];
    assign AND    = w_alu[ALU_AND];
    assign OR     = w_alu[ALU_OR];
    assign NEGATE = w_alu[ALU_NEGATE];
    assign NOT    = w_alu[ALU_NOT];

    assign busy    = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign halted  = (state_q == ST_HALT);
    assign illegal = illegal_q;

endmodule

`default_nettype wire
